memphy_seq: RTL and testbench
=============================

Name: memphy_seq

Overview:
Parametrised DDR PHY sequencer sitting between the memory controller and the per-lane DDIO/DQS pad logic in the clk domain. Turns read/write burst commands into cycle-exact control of DQ drive, DQS preamble/postamble and read-capture windows across LANES byte lanes. Generalises the single-lane PHY in two ways:
- configurable write and read latency;
- a built-in read-latency calibration mode using a known write/readback pattern.

Parameters:
LANES, 1, number of 8-bit byte lanes; each lane carries 16 bits per clk (two DDR beats).
BURST, 4, clk cycles per burst (2*BURST DDR beats); range 2..8.
WL, 2, write latency in clk cycles from cmd_issue to first data cycle; range 1..8.
RLMAX, 15, largest read latency probed in calibration; range 2..15.
RL_INIT, 5, read latency in use after reset; range 1..RLMAX.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  controller command request.
cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
cmd_we  in  1  1=write burst, 0=read burst; sampled at acceptance.
wr_data  in  16*LANES  write data; must be valid on every cycle wr_ready=1.
wr_ready  out  1  high on each data cycle of a write burst; wr_data is consumed that cycle.
rd_data  out  16*LANES  registered captured read data.
rd_valid  out  1  high for BURST consecutive cycles per read.
cmd_issue  out  1  one-cycle pulse telling the command/address driver to issue to DRAM.
cmd_issue_we  out  1  type of the issued command; valid when cmd_issue=1.
ddrdqout  out  16*LANES  data to DDIO output registers.
ddrdqt  out  1  DQ tristate; 1=released.
ddrdqspre  out  1  DQS pre/postamble drive request.
ddrdqin  in  16*LANES  data from DDIO input registers.
cal_start  in  1  pulse; starts calibration. Honoured only in IDLE; ignored otherwise.
cal_done  out  1  sticky; set on successful calibration.
cal_fail  out  1  sticky; set on failed calibration.
rl  out  4  read latency currently in use.

Behaviour:
- Reset values:
  - State IDLE; cmd_ready=1.
  - wr_ready, rd_valid, cmd_issue, cmd_issue_we, ddrdqspre, cal_done, cal_fail = 0.
  - ddrdqt=1; ddrdqout=0; rd_data=0; rl=RL_INIT.
  - Reset mid-burst or mid-calibration aborts immediately to these values.
- States: IDLE, WLAT, WDATA, WPOST, RWAIT, CWR, CWLAT, CWDATA, CWPOST, CRD.
- Priority in IDLE: cal_start beats cmd_valid. When both are high, cmd_ready drops the next cycle and the command is not accepted.
- Write path:
  - Acceptance at cycle T. cmd_issue=1 and cmd_issue_we=1 at T+1.
  - WLAT covers T+1..T+WL. ddrdqt=1 throughout; ddrdqspre=1 in cycle T+WL only (preamble).
  - WDATA covers T+WL+1..T+WL+BURST. ddrdqt=0, wr_ready=1, ddrdqout=wr_data (registered-through, zero added latency).
  - WPOST is one cycle: ddrdqt=1, ddrdqspre=1 (postamble), ddrdqout=0.
  - Then IDLE; cmd_ready=1 on the following cycle.
- Read path:
  - Acceptance at T. cmd_issue=1 and cmd_issue_we=0 at T+1.
  - ddrdqin is captured at cycles T+1+rl .. T+rl+BURST into rd_data, one cycle of register latency.
  - rd_valid is therefore high for cycles T+2+rl .. T+1+rl+BURST.
  - RWAIT holds cmd_ready=0 until the cycle after the last rd_valid.
  - ddrdqt stays 1 throughout the read.
- Calibration sequence:
  - cal_start clears cal_done and cal_fail.
  - CWR/CWLAT/CWDATA/CWPOST perform an internal write with timing identical to the write path. Data word k (k=0..BURST-1) is {LANES{16'hA55A ^ (k*16'h1111)}}. wr_ready stays 0.
  - CRD issues an internal read (cmd_issue=1, cmd_issue_we=0), then counts c=1..RLMAX cycles after issue.
  - The first c where ddrdqin==word0 in cycle c and ddrdqin==word1 in cycle c+1 wins: rl<=c, cal_done<=1.
  - If no such c exists, cal_fail<=1 and rl is unchanged.
  - Then IDLE. rd_valid is never asserted during calibration.
- A new read uses the updated rl from the first read after cal_done.
- rl is applied as 4-bit unsigned; window counters are sized for RLMAX+BURST+2.

Test Plan:
- LANES=2, WL=2, BURST=4; accept write at T with wr_data=32'h0102_0304.. -> cmd_issue@T+1; ddrdqspre@T+2; ddrdqt=0 and wr_ready=1 @T+3..T+6; postamble ddrdqspre@T+7; cmd_ready=1 @T+8.
- rl=5, read accepted at T; model drives 0x1111,0x2222,0x3333,0x4444 at T+6..T+9 -> rd_valid@T+7..T+10 with the same words in order; ddrdqt=1 throughout.
- Calibration with model returning the written pattern 7 cycles after read issue -> cal_done=1, rl=7, cal_fail=0; next read shows rd_valid starting at T+9.
- Calibration with model returning only zeros -> cal_fail=1, cal_done=0, rl keeps its prior value (5).
- cal_start and cmd_valid high together in IDLE -> calibration runs; the command is accepted only after return to IDLE.
- rst asserted during WDATA -> next cycle ddrdqt=1, ddrdqspre=0, wr_ready=0, cmd_ready=1, rl=RL_INIT.

Source files
------------

// File: rtl/memphy_seq.sv
// memphy_seq -- DDR PHY sequencer between the memory controller and the
// per-lane DDIO/DQS pad logic. Turns burst commands into cycle-exact DQ drive,
// DQS pre/postamble and read-capture windows, and can calibrate its own read
// latency with a known write/readback pattern.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_we selects write/read
//   wr_data/wr_ready         write data, consumed on every wr_ready cycle
//   rd_data/rd_valid         registered read data, BURST cycles per read
//   cmd_issue/cmd_issue_we   one-cycle pulse to the command/address driver
//   ddrdqout/ddrdqt          DQ data and tristate (1 = released) to the pads
//   ddrdqspre                DQS pre/postamble drive request
//   ddrdqin                  data captured by the DDIO input registers
//   cal_start/cal_done/cal_fail  calibration pulse and sticky result flags
//   rl                       read latency currently in use
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready and
// cal_start is low; cmd_ready is high exactly while the sequencer is idle, and
// cal_start in the same cycle wins, so the command stays pending and is
// accepted only after the calibration returns to idle. wr_data has no valid:
// the producer must present fresh data on every cycle wr_ready is high.
module memphy_seq #(
  parameter int LANES   = 1,
  parameter int BURST   = 4,
  parameter int WL      = 2,
  parameter int RLMAX   = 15,
  parameter int RL_INIT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [16*LANES-1:0]   wr_data,
  output logic                  wr_ready,
  output logic [16*LANES-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  cmd_issue,
  output logic                  cmd_issue_we,
  output logic [16*LANES-1:0]   ddrdqout,
  output logic                  ddrdqt,
  output logic                  ddrdqspre,
  input  logic [16*LANES-1:0]   ddrdqin,
  input  logic                  cal_start,
  output logic                  cal_done,
  output logic                  cal_fail,
  output logic [3:0]            rl
);

  localparam int DW = 16 * LANES;
  // Counter spans the longest read window (RLMAX + BURST + 2); at least 5 bits
  // so the 4-bit rl always fits with headroom.
  localparam int CW_RAW = $clog2(RLMAX + BURST + 3);
  localparam int CW     = (CW_RAW > 5) ? CW_RAW : 5;

  localparam logic [CW-1:0] WL_M1     = CW'(WL - 1);
  localparam logic [CW-1:0] BURST_M1  = CW'(BURST - 1);
  localparam logic [CW-1:0] RLMAX_P1  = CW'(RLMAX + 1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_WLAT, S_WDATA, S_WPOST, S_RWAIT,
    S_CWR, S_CWLAT, S_CWDATA, S_CWPOST, S_CRD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     rl_q, rl_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           cal_done_q, cal_done_d;
  logic           cal_fail_q, cal_fail_d;
  logic           match0_q, match0_d;

  logic [CW-1:0]  rl_ext;
  logic           rd_window;

  // Calibration word k: 16'hA55A ^ (k * 16'h1111), replicated on every lane.
  function automatic logic [DW-1:0] cal_word(input logic [CW-1:0] k);
    logic [15:0] w;
    w = 16'hA55A ^ (16'(k) * 16'h1111);
    return {LANES{w}};
  endfunction

  assign rl_ext = {{(CW - 4){1'b0}}, rl_q};
  // In RWAIT the counter equals cycles since issue; capture while it lies in
  // [rl, rl + BURST - 1].
  assign rd_window = (cnt_q >= rl_ext) && (cnt_q < (rl_ext + CW'(BURST)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    rl_d         = rl_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    cal_done_d   = cal_done_q;
    cal_fail_d   = cal_fail_q;
    // Remembers whether the previous cycle carried word 0 of the pattern.
    match0_d     = (ddrdqin == cal_word('0));
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    cmd_issue    = 1'b0;
    cmd_issue_we = 1'b0;
    ddrdqout     = '0;
    ddrdqt       = 1'b1;
    ddrdqspre    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cal_start) begin
          cal_done_d = 1'b0;
          cal_fail_d = 1'b0;
          state_d    = S_CWR;
        end else if (cmd_valid) begin
          state_d = cmd_we ? S_WLAT : S_RWAIT;
        end
      end
      S_WLAT: begin
        cmd_issue    = (cnt_q == '0);
        cmd_issue_we = (cnt_q == '0);
        ddrdqspre    = (cnt_q == WL_M1);
        if (cnt_q == WL_M1) begin
          state_d = S_WDATA;
          cnt_d   = '0;
        end
      end
      S_WDATA: begin
        ddrdqt   = 1'b0;
        wr_ready = 1'b1;
        ddrdqout = wr_data;
        if (cnt_q == BURST_M1) state_d = S_WPOST;
      end
      S_WPOST: begin
        ddrdqspre = 1'b1;
        state_d   = S_IDLE;
      end
      S_RWAIT: begin
        cmd_issue = (cnt_q == '0);
        if (rd_window) begin
          rd_valid_d = 1'b1;
          rd_data_d  = ddrdqin;
        end
        // Leave once the last rd_valid is being presented.
        if (cnt_q == (rl_ext + CW'(BURST))) state_d = S_IDLE;
      end
      // Internal write: CWR is the issue cycle, CWLAT the rest of WL, so the
      // combined timing matches WLAT exactly (including WL == 1).
      S_CWR, S_CWLAT: begin
        cmd_issue    = (state_q == S_CWR);
        cmd_issue_we = (state_q == S_CWR);
        ddrdqspre    = (cnt_q == WL_M1);
        if (cnt_q == WL_M1) begin
          state_d = S_CWDATA;
          cnt_d   = '0;
        end else begin
          state_d = S_CWLAT;
        end
      end
      S_CWDATA: begin
        ddrdqt   = 1'b0;
        ddrdqout = cal_word(cnt_q);
        if (cnt_q == BURST_M1) state_d = S_CWPOST;
      end
      S_CWPOST: begin
        ddrdqspre = 1'b1;
        state_d   = S_CRD;
        cnt_d     = '0;
      end
      S_CRD: begin
        cmd_issue = (cnt_q == '0);
        // Candidate latency c = cnt - 1: word0 seen at c, word1 now at c + 1.
        if ((cnt_q >= CNT_TWO) && match0_q && (ddrdqin == cal_word(CNT_ONE))) begin
          rl_d       = 4'(cnt_q - CNT_ONE);
          cal_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == RLMAX_P1) begin
          cal_fail_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rl_q       <= 4'(RL_INIT);
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
      match0_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rl_q       <= rl_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cal_done_q <= cal_done_d;
      cal_fail_q <= cal_fail_d;
      match0_q   <= match0_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign cal_done = cal_done_q;
  assign cal_fail = cal_fail_q;
  assign rl       = rl_q;

endmodule

// File: tb/tb_memphy_seq.sv
// tb_memphy_seq -- directed bench for memphy_seq with LANES=2, BURST=4, WL=2,
// RLMAX=15, RL_INIT=5. Inputs change 1 time unit after each rising edge and
// outputs are checked on the falling edge.
module tb_memphy_seq;

  localparam int LANES = 2;
  localparam int DW    = 16 * LANES;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, cmd_issue, cmd_issue_we;
  logic [DW-1:0] ddrdqout;
  logic          ddrdqt, ddrdqspre;
  logic [DW-1:0] ddrdqin;
  logic          cal_start, cal_done, cal_fail;
  logic [3:0]    rl;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   pat[4] = '{16'hA55A, 16'hB44B, 16'h8778, 16'h9669};

  memphy_seq #(.LANES(LANES), .BURST(4), .WL(2), .RLMAX(15), .RL_INIT(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .cmd_issue(cmd_issue),
    .cmd_issue_we(cmd_issue_we), .ddrdqout(ddrdqout), .ddrdqt(ddrdqt),
    .ddrdqspre(ddrdqspre), .ddrdqin(ddrdqin), .cal_start(cal_start),
    .cal_done(cal_done), .cal_fail(cal_fail), .rl(rl)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read accepted in the current cycle T; pattern driven at T+rlv+1..T+rlv+4,
  // rd_valid expected at T+rlv+2..T+rlv+5 and cmd_ready back at T+rlv+6.
  task automatic run_read(input int rlv, input logic pulse_cal);
    logic [15:0] w;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    @(negedge clk);
    check("rd_accept_ready", cmd_ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      w = 16'(k) * 16'h1111;
      exp_q.push_back({~w, w});
    end
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= rlv + 6; i++) begin
      if (i >= rlv + 1 && i <= rlv + 4) begin
        w = 16'(i - rlv) * 16'h1111;
        ddrdqin = {~w, w};
      end else begin
        ddrdqin = 32'hDEAD_BEEF;
      end
      cal_start = pulse_cal && (i == 3);
      @(negedge clk);
      check("rd_issue", cmd_issue, (i == 1));
      check("rd_issue_we", cmd_issue_we, 1'b0);
      check("rd_dqt", ddrdqt, 1'b1);
      check("rd_valid", rd_valid, (i >= rlv + 2 && i <= rlv + 5));
      check("rd_cmd_ready", cmd_ready, (i == rlv + 6));
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_extra_beat", 1'b1, 1'b0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end
      step();
    end
    cal_start = 1'b0;
    ddrdqin   = '0;
    check("rd_beats_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; wr_data = '0;
    ddrdqin = '0; cal_start = 1'b0;
    repeat (2) step();

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_cmd_issue", cmd_issue, 1'b0);
    check("rst_cmd_issue_we", cmd_issue_we, 1'b0);
    check("rst_dqspre", ddrdqspre, 1'b0);
    check("rst_cal_done", cal_done, 1'b0);
    check("rst_cal_fail", cal_fail, 1'b0);
    check("rst_dqt", ddrdqt, 1'b1);
    check("rst_dqout", ddrdqout, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rl", rl, 4'd5);
    step();
    rst = 1'b0;
    step();

    // Write burst accepted at T
    cmd_valid = 1'b1; cmd_we = 1'b1; wr_data = 32'h0102_0304;
    @(negedge clk);
    check("wr_accept_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 32'h0102_0304 + 32'(i) * 32'h1010_1010;
      @(negedge clk);
      check("wr_issue", cmd_issue, (i == 1));
      check("wr_issue_we", cmd_issue_we, (i == 1));
      check("wr_dqspre", ddrdqspre, (i == 2 || i == 7));
      check("wr_dqt", ddrdqt, !(i >= 3 && i <= 6));
      check("wr_ready", wr_ready, (i >= 3 && i <= 6));
      check("wr_dqout", ddrdqout, (i >= 3 && i <= 6) ? wr_data : 32'h0);
      check("wr_cmd_ready", cmd_ready, (i == 8));
      step();
    end
    wr_data = '0;

    // Read with reset latency
    run_read(5, 1'b0);

    // Failing calibration, with a read command held pending alongside cal_start
    cal_start = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b0; ddrdqin = '0;
    @(negedge clk);
    check("calf_start_ready", cmd_ready, 1'b1);
    step();
    cal_start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      check("calf_cmd_ready", cmd_ready, 1'b0);
      check("calf_issue", cmd_issue, (i == 1 || i == 8));
      check("calf_rd_valid", rd_valid, 1'b0);
      check("calf_fail_early", cal_fail, 1'b0);
      step();
    end
    // Returns to idle at T+25; the held read is accepted there with rl still 5.
    run_read(5, 1'b0);
    check("calf_fail", cal_fail, 1'b1);
    check("calf_done", cal_done, 1'b0);
    check("calf_rl", rl, 4'd5);

    // Successful calibration: pattern returned 7 cycles after the read issue
    // (issue at T+8), with a lone word0 decoy at T+11.
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i == 11) ddrdqin = {2{pat[0]}};
      else if (i >= 15 && i <= 17) ddrdqin = {2{pat[i - 15]}};
      else ddrdqin = '0;
      wr_data = 32'hFFFF_0000 ^ 32'(i);
      @(negedge clk);
      check("cal_issue", cmd_issue, (i == 1 || i == 8));
      check("cal_issue_we", cmd_issue_we, (i == 1));
      check("cal_dqspre", ddrdqspre, (i == 2 || i == 7));
      check("cal_dqt", ddrdqt, !(i >= 3 && i <= 6));
      check("cal_dqout", ddrdqout, (i >= 3 && i <= 6) ? {2{pat[(i >= 3 && i <= 6) ? i - 3 : 0]}} : 32'h0);
      check("cal_wr_ready", wr_ready, 1'b0);
      check("cal_rd_valid", rd_valid, 1'b0);
      check("cal_cmd_ready", cmd_ready, (i == 17));
      check("cal_done", cal_done, (i == 17));
      check("cal_fail", cal_fail, 1'b0);
      check("cal_rl", rl, (i == 17) ? 4'd7 : 4'd5);
      step();
    end
    ddrdqin = '0; wr_data = '0;

    // Read with calibrated latency; cal_start during the read must be ignored
    run_read(7, 1'b1);
    check("post_cal_done", cal_done, 1'b1);
    check("post_rl", rl, 4'd7);

    // Reset asserted during WDATA
    cmd_valid = 1'b1; cmd_we = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_in_wdata", wr_ready, 1'b1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_dqt", ddrdqt, 1'b1);
    check("rstmid_dqspre", ddrdqspre, 1'b0);
    check("rstmid_wr_ready", wr_ready, 1'b0);
    check("rstmid_cmd_ready", cmd_ready, 1'b1);
    check("rstmid_rl", rl, 4'd5);
    check("rstmid_cal_done", cal_done, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
